rom_arbiter: RTL and testbench

Shares the single combinational instruction ROM (9-bit word address, 32-bit data) between the CPU fetch port and a debug/loader burst-read port. Fetch has priority every cycle. A starvation counter forces a debug slot after a bounded wait. Responses are registered, so read data arrives one cycle after the grant. The block sits between the fetch stage, the debug controller, and `rom`.

---
 rtl/rom_arbiter_pkg.sv | 13 +
 rtl/rom_arbiter_if.sv | 32 +++
 rtl/rom_burst_gen.sv | 44 ++++
 rtl/rom_arbiter.sv | 98 +++++++++
 tb/tb_rom_arbiter.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_arbiter_pkg.sv
// Shared widths and state encoding for the instruction-ROM arbiter.
package rom_arbiter_pkg;

  localparam int ROM_AW = 9;
  localparam int ROM_DW = 32;
  localparam int WAIT_W = 4;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rom_arbiter_if.sv
// Fetch, debug-burst and ROM signals bundled between the arbiter and its clients.
interface rom_arbiter_if;
  import rom_arbiter_pkg::*;

  logic              f_req;
  logic [ROM_AW-1:0] f_adrs;
  logic              f_gnt;
  logic              f_rvalid;
  logic [ROM_DW-1:0] f_rdata;

  logic              d_req;
  logic [ROM_AW-1:0] d_adrs;
  logic [ROM_AW-1:0] d_len;
  logic              d_ack;
  logic              d_rvalid;
  logic [ROM_DW-1:0] d_rdata;
  logic              d_done;

  logic [ROM_AW-1:0] rom_adrs;
  logic [ROM_DW-1:0] rom_dout;

  modport slave (
    input  f_req, f_adrs, d_req, d_adrs, d_len, rom_dout,
    output f_gnt, f_rvalid, f_rdata, d_ack, d_rvalid, d_rdata, d_done, rom_adrs
  );

  modport master (
    output f_req, f_adrs, d_req, d_adrs, d_len, rom_dout,
    input  f_gnt, f_rvalid, f_rdata, d_ack, d_rvalid, d_rdata, d_done, rom_adrs
  );

endinterface

// File: rtl/rom_burst_gen.sv
// Debug burst address walker: current word address and words remaining.
// The address wraps naturally at the 9-bit boundary; last_o flags the final word.
module rom_burst_gen
  import rom_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ROM_AW-1:0] adrs_i,
  input  logic [ROM_AW-1:0] len_i,
  input  logic              step_i,
  output logic [ROM_AW-1:0] cur_o,
  output logic              last_o
);

  logic [ROM_AW-1:0] cur_q, cur_d;
  logic [ROM_AW-1:0] rem_q, rem_d;

  always_comb begin
    cur_d = cur_q;
    rem_d = rem_q;
    if (load_i) begin
      cur_d = adrs_i;
      rem_d = len_i;
    end else if (step_i) begin
      cur_d = cur_q + 1'b1;
      if (rem_q != '0) rem_d = rem_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q <= '0;
      rem_q <= '0;
    end else begin
      cur_q <= cur_d;
      rem_q <= rem_d;
    end
  end

  assign cur_o  = cur_q;
  assign last_o = (rem_q == '0);

endmodule

// File: rtl/rom_arbiter.sv
// Shares the instruction ROM between CPU fetch (priority) and debug bursts,
// with a starvation counter that forces a debug slot after MAX_WAIT denials.
//   state     | meaning
//   ARB_IDLE  | fetch owns the ROM; a debug request is accepted here
//   ARB_BURST | per-cycle choice between fetch and the next debug word
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input logic          clk,
  input logic          rst,
  rom_arbiter_if.slave bus
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  arb_state_e        state_q;
  logic [WAIT_W-1:0] wait_q;
  logic              d_ack_q;
  logic              f_rvalid_q;
  logic [ROM_DW-1:0] f_rdata_q;
  logic              d_rvalid_q;
  logic [ROM_DW-1:0] d_rdata_q;
  logic              d_done_q;

  logic              in_burst;
  logic              fetch_own;
  logic              dbg_issue;
  logic              accept;
  logic              f_gnt;
  logic [ROM_AW-1:0] cur;
  logic              last;

  assign in_burst  = (state_q == ARB_BURST);
  assign fetch_own = bus.f_req && (wait_q < MAX_WAIT_C);
  assign dbg_issue = in_burst && !fetch_own;
  assign accept    = !in_burst && bus.d_req;
  assign f_gnt     = bus.f_req && !dbg_issue;

  rom_burst_gen u_burst_gen (
    .clk    (clk),
    .rst    (rst),
    .load_i (accept),
    .adrs_i (bus.d_adrs),
    .len_i  (bus.d_len),
    .step_i (dbg_issue),
    .cur_o  (cur),
    .last_o (last)
  );

  assign bus.rom_adrs = dbg_issue ? cur : bus.f_adrs;
  assign bus.f_gnt    = f_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      wait_q     <= '0;
      d_ack_q    <= 1'b0;
      f_rvalid_q <= 1'b0;
      f_rdata_q  <= '0;
      d_rvalid_q <= 1'b0;
      d_rdata_q  <= '0;
      d_done_q   <= 1'b0;
    end else begin
      d_ack_q    <= accept;
      f_rvalid_q <= f_gnt;
      d_rvalid_q <= dbg_issue;
      d_done_q   <= dbg_issue && last;
      if (f_gnt)     f_rdata_q <= bus.rom_dout;
      if (dbg_issue) d_rdata_q <= bus.rom_dout;

      unique case (state_q)
        ARB_IDLE: begin
          wait_q <= '0;
          if (bus.d_req) state_q <= ARB_BURST;
        end
        ARB_BURST: begin
          if (dbg_issue) begin
            wait_q <= '0;
            if (last) state_q <= ARB_IDLE;
          end else if (wait_q != {WAIT_W{1'b1}}) begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign bus.d_ack    = d_ack_q;
  assign bus.f_rvalid = f_rvalid_q;
  assign bus.f_rdata  = f_rdata_q;
  assign bus.d_rvalid = d_rvalid_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.d_done   = d_done_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: directed vector table, corner-case sequences and
// randomized traffic against a queue-based reference model.
module tb_rom_arbiter;
  import rom_arbiter_pkg::*;

  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rom_arbiter_if bus();

  rom_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.rom_dout = 32'hA5A50000 | {23'd0, bus.rom_adrs};

  typedef struct {
    logic        f_gnt;
    logic [8:0]  rom_adrs;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        d_ack;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_done;
  } outs_t;

  typedef struct {
    bit    f_req;
    int    f_adrs;
    bit    d_req;
    int    d_adrs;
    int    d_len;
    outs_t exp;
  } vec_t;

  int n_checks = 0;
  int n_err    = 0;

  // reference model: pending burst words kept as a list of addresses
  bit          m_busy = 1'b0;
  int          m_denied = 0;
  int          m_q[$];
  logic        e_f_rv = 1'b0, e_d_ack = 1'b0, e_d_rv = 1'b0, e_d_done = 1'b0;
  logic [31:0] e_f_rd = '0, e_d_rd = '0;

  function automatic logic [31:0] rom_of(int a);
    return 32'hA5A50000 | 32'(a & 511);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic chk_outs(string tag, outs_t o, outs_t e);
    chk({tag, ".f_gnt"},    32'(o.f_gnt),    32'(e.f_gnt));
    chk({tag, ".rom_adrs"}, 32'(o.rom_adrs), 32'(e.rom_adrs));
    chk({tag, ".f_rvalid"}, 32'(o.f_rvalid), 32'(e.f_rvalid));
    chk({tag, ".f_rdata"},  o.f_rdata,       e.f_rdata);
    chk({tag, ".d_ack"},    32'(o.d_ack),    32'(e.d_ack));
    chk({tag, ".d_rvalid"}, 32'(o.d_rvalid), 32'(e.d_rvalid));
    chk({tag, ".d_rdata"},  o.d_rdata,       e.d_rdata);
    chk({tag, ".d_done"},   32'(o.d_done),   32'(e.d_done));
  endtask

  // One clock cycle: apply inputs, sample and check against the model, advance.
  task automatic cycle(input bit r, input bit fr, input int fa, input bit dr,
                       input int da, input int dl, output outs_t o);
    outs_t e;
    bit    dbg;
    bit    was_busy;
    int    ra;
    rst        = r;
    bus.f_req  = fr;
    bus.f_adrs = 9'(fa);
    bus.d_req  = dr;
    bus.d_adrs = 9'(da);
    bus.d_len  = 9'(dl);
    #3;
    o.f_gnt    = bus.f_gnt;
    o.rom_adrs = bus.rom_adrs;
    o.f_rvalid = bus.f_rvalid;
    o.f_rdata  = bus.f_rdata;
    o.d_ack    = bus.d_ack;
    o.d_rvalid = bus.d_rvalid;
    o.d_rdata  = bus.d_rdata;
    o.d_done   = bus.d_done;

    dbg = 1'b0;
    if (!m_busy || (fr && m_denied < MAX_WAIT)) begin
      e.f_gnt = fr;
      ra      = fa & 511;
    end else begin
      e.f_gnt = 1'b0;
      dbg     = 1'b1;
      ra      = m_q[0];
    end
    e.rom_adrs = 9'(ra);
    e.f_rvalid = e_f_rv;
    e.f_rdata  = e_f_rd;
    e.d_ack    = e_d_ack;
    e.d_rvalid = e_d_rv;
    e.d_rdata  = e_d_rd;
    e.d_done   = e_d_done;
    chk_outs("model", o, e);

    was_busy = m_busy;
    if (r) begin
      m_busy = 1'b0; m_denied = 0; m_q.delete();
      e_f_rv = 1'b0; e_d_ack = 1'b0; e_d_rv = 1'b0; e_d_done = 1'b0;
      e_f_rd = '0;   e_d_rd = '0;
    end else begin
      e_d_ack  = !was_busy && dr;
      e_f_rv   = e.f_gnt;
      e_d_rv   = dbg;
      e_d_done = 1'b0;
      if (e.f_gnt) e_f_rd = rom_of(fa);
      if (dbg) begin
        e_d_rd = rom_of(ra);
        void'(m_q.pop_front());
        m_denied = 0;
        if (m_q.size() == 0) begin
          m_busy   = 1'b0;
          e_d_done = 1'b1;
        end
      end else if (was_busy && m_denied < 15) begin
        m_denied++;
      end
      if (!was_busy && dr) begin
        for (int k = 0; k <= dl; k++) m_q.push_back((da + k) % 512);
        m_busy   = 1'b1;
        m_denied = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  vec_t  tbl[9];
  outs_t o;
  outs_t zero_o;

  initial begin
    int lowmask, done_at, ackmask, done_idx, n_done;
    int wq[$];
    bit fr, dr, r;
    int fa, da, dl;

    tbl[0] = '{1, 0, 0, 0, 0, '{1, 0, 0, 32'h0,        0, 0, 32'h0,        0}};
    tbl[1] = '{1, 1, 0, 0, 0, '{1, 1, 1, 32'hA5A50000, 0, 0, 32'h0,        0}};
    tbl[2] = '{1, 2, 0, 0, 0, '{1, 2, 1, 32'hA5A50001, 0, 0, 32'h0,        0}};
    tbl[3] = '{0, 0, 1, 5, 2, '{0, 0, 1, 32'hA5A50002, 0, 0, 32'h0,        0}};
    tbl[4] = '{0, 0, 0, 0, 0, '{0, 5, 0, 32'hA5A50002, 1, 0, 32'h0,        0}};
    tbl[5] = '{0, 0, 0, 0, 0, '{0, 6, 0, 32'hA5A50002, 0, 1, 32'hA5A50005, 0}};
    tbl[6] = '{0, 0, 0, 0, 0, '{0, 7, 0, 32'hA5A50002, 0, 1, 32'hA5A50006, 0}};
    tbl[7] = '{0, 0, 0, 0, 0, '{0, 0, 0, 32'hA5A50002, 0, 1, 32'hA5A50007, 1}};
    tbl[8] = '{0, 0, 0, 0, 0, '{0, 0, 0, 32'hA5A50002, 0, 0, 32'hA5A50007, 0}};
    zero_o = '{0, 0, 0, 32'h0, 0, 0, 32'h0, 0};

    rst = 1'b1;
    bus.f_req = 1'b0; bus.f_adrs = '0; bus.d_req = 1'b0; bus.d_adrs = '0; bus.d_len = '0;
    repeat (2) @(posedge clk);
    #4;
    o.f_gnt = bus.f_gnt; o.rom_adrs = bus.rom_adrs; o.f_rvalid = bus.f_rvalid;
    o.f_rdata = bus.f_rdata; o.d_ack = bus.d_ack; o.d_rvalid = bus.d_rvalid;
    o.d_rdata = bus.d_rdata; o.d_done = bus.d_done;
    chk_outs("reset", o, zero_o);
    @(posedge clk);
    #1;

    // fetch-only stream followed by an idle-fetch burst
    for (int i = 0; i < 9; i++) begin
      cycle(0, tbl[i].f_req, tbl[i].f_adrs, tbl[i].d_req, tbl[i].d_adrs, tbl[i].d_len, o);
      chk_outs($sformatf("vec%0d", i), o, tbl[i].exp);
    end

    // starvation under continuous fetch, two-word burst
    lowmask = 0; done_at = -1;
    cycle(0, 1, 20, 1, 100, 1, o);
    for (int k = 1; k <= 12; k++) begin
      cycle(0, 1, 20, 0, 0, 0, o);
      if (!o.f_gnt) lowmask |= (1 << k);
      if (o.d_done) done_at = k;
    end
    chk("starve_gnt_low_mask", 32'(lowmask), 32'((1 << 5) | (1 << 10)));
    chk("starve_done_cycle", 32'(done_at), 32'd11);

    // address wrap 510, 511, 0, 1
    done_idx = -1;
    cycle(0, 0, 0, 1, 510, 3, o);
    for (int k = 1; k <= 6; k++) begin
      cycle(0, 0, 0, 0, 0, 0, o);
      if (o.d_rvalid) begin
        wq.push_back(int'(o.d_rdata[8:0]));
        if (o.d_done) done_idx = wq.size() - 1;
      end
    end
    chk("wrap_count", 32'(wq.size()), 32'd4);
    if (wq.size() == 4) begin
      chk("wrap_w0", 32'(wq[0]), 32'd510);
      chk("wrap_w1", 32'(wq[1]), 32'd511);
      chk("wrap_w2", 32'(wq[2]), 32'd0);
      chk("wrap_w3", 32'(wq[3]), 32'd1);
    end
    chk("wrap_done_idx", 32'(done_idx), 32'd3);

    // reset in the middle of a four-word burst
    cycle(0, 0, 0, 1, 50, 3, o);
    cycle(0, 0, 0, 0, 0, 0, o);
    cycle(1, 0, 0, 0, 0, 0, o);
    cycle(0, 0, 0, 0, 0, 0, o);
    chk_outs("after_rst", o, zero_o);
    n_done = 0;
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 0, 0, 0, 0, o);
      if (o.d_done || o.d_rvalid) n_done++;
    end
    chk("rst_no_tail", 32'(n_done), 32'd0);
    cycle(0, 0, 0, 1, 200, 0, o);
    cycle(0, 0, 0, 0, 0, 0, o);
    chk("restart_ack", 32'(o.d_ack), 32'd1);
    cycle(0, 0, 0, 0, 0, 0, o);
    chk("restart_rdata", o.d_rdata, 32'hA5A500C8);
    chk("restart_done", 32'(o.d_done), 32'd1);

    // d_req held high across two back-to-back bursts
    ackmask = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(0, 0, 0, 1, 300, 1, o);
      if (o.d_ack) ackmask |= (1 << k);
    end
    chk("held_ack_mask", 32'(ackmask), 32'((1 << 1) | (1 << 4) | (1 << 7)));
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0, 0, 0, o);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      fr = ($urandom_range(0, 9) < 7);
      fa = int'($urandom_range(0, 511));
      dr = ($urandom_range(0, 4) == 0);
      da = int'($urandom_range(0, 511));
      dl = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 511))
                                        : int'($urandom_range(0, 7));
      cycle(r, fr, fa, dr, da, dl, o);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
